// File: rtl/ex_stage.sv
// Execute stage: operand forwarding, single-cycle ALU, 32-cycle shift-add multiplier
// and the EX/MEM pipeline register.
module ex_stage #(
    parameter int MUL_CYCLES = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [1:0]  ALUOp_EX,
    input  logic        RegDst_EX,
    input  logic        ALUSrc_EX,
    input  logic        MemRead_EX,
    input  logic        MemWrite_EX,
    input  logic        MemtoReg_EX,
    input  logic        RegWrite_EX,
    input  logic [31:0] regReadData1_EX,
    input  logic [31:0] regReadData2_EX,
    input  logic [31:0] signExtend_EX,
    input  logic [4:0]  Rt_EX,
    input  logic [4:0]  Rd_EX,
    input  logic [1:0]  ForwardA,
    input  logic [1:0]  ForwardB,
    input  logic [31:0] writeData_WB,
    output logic [31:0] ALUResult_MEM,
    output logic [31:0] storeData_MEM,
    output logic [4:0]  writeReg_MEM,
    output logic        MemRead_MEM,
    output logic        MemWrite_MEM,
    output logic        MemtoReg_MEM,
    output logic        RegWrite_MEM,
    output logic        mulBusy
);

    typedef enum logic {IDLE, BUSY} state_t;

    localparam logic [4:0] LAST_CNT = 5'(MUL_CYCLES - 1);

    state_t      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [31:0] acc_q, acc_d;
    logic [31:0] mcand_q, mcand_d;
    logic [31:0] mplier_q, mplier_d;

    logic [31:0] opA, fwdB, opB, aluResult, mulTerm, aluRes_d;
    logic [5:0]  funct;
    logic        isMul, busyRaw, bubble, mulDone;

    function automatic logic [31:0] fwdSel(input logic [1:0]  sel,
                                           input logic [31:0] rf,
                                           input logic [31:0] mem,
                                           input logic [31:0] wb);
        case (sel)
            2'b10:   return mem;
            2'b01:   return wb;
            default: return rf;
        endcase
    endfunction

    assign opA   = fwdSel(ForwardA, regReadData1_EX, ALUResult_MEM, writeData_WB);
    assign fwdB  = fwdSel(ForwardB, regReadData2_EX, ALUResult_MEM, writeData_WB);
    assign opB   = ALUSrc_EX ? signExtend_EX : fwdB;
    assign funct = signExtend_EX[5:0];
    assign isMul = (ALUOp_EX == 2'b10) && (funct == 6'h18) && RegWrite_EX;

    // Single-cycle ALU; funct 0x18 is handled by the multiplier, not here
    always_comb begin
        aluResult = '0;
        case (ALUOp_EX)
            2'b00: aluResult = opA + opB;
            2'b01: aluResult = opA - opB;
            2'b11: aluResult = {31'd0, $signed(opA) < $signed(opB)};
            default: begin
                case (funct)
                    6'h20:   aluResult = opA + opB;
                    6'h22:   aluResult = opA - opB;
                    6'h24:   aluResult = opA & opB;
                    6'h25:   aluResult = opA | opB;
                    6'h2A:   aluResult = {31'd0, $signed(opA) < $signed(opB)};
                    default: aluResult = '0;
                endcase
            end
        endcase
    end

    assign mulTerm = mplier_q[cnt_q] ? (mcand_q << cnt_q) : 32'd0;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        busyRaw  = 1'b0;
        bubble   = 1'b0;
        mulDone  = 1'b0;
        case (state_q)
            IDLE: begin
                if (isMul) begin
                    busyRaw  = 1'b1;
                    bubble   = 1'b1;
                    mcand_d  = opA;
                    mplier_d = opB;
                    acc_d    = '0;
                    cnt_d    = '0;
                    state_d  = BUSY;
                end
            end
            default: begin
                acc_d = acc_q + mulTerm;
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == LAST_CNT) begin
                    // Upstream advances on this edge, so the mul is not seen again
                    mulDone = 1'b1;
                    cnt_d   = '0;
                    state_d = IDLE;
                end else begin
                    busyRaw = 1'b1;
                    bubble  = 1'b1;
                end
            end
        endcase
    end

    assign aluRes_d = mulDone ? (acc_q + mulTerm) : aluResult;
    assign mulBusy  = rst_n & busyRaw;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            acc_q         <= '0;
            mcand_q       <= '0;
            mplier_q      <= '0;
            ALUResult_MEM <= '0;
            storeData_MEM <= '0;
            writeReg_MEM  <= '0;
            MemRead_MEM   <= 1'b0;
            MemWrite_MEM  <= 1'b0;
            MemtoReg_MEM  <= 1'b0;
            RegWrite_MEM  <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            acc_q         <= acc_d;
            mcand_q       <= mcand_d;
            mplier_q      <= mplier_d;
            ALUResult_MEM <= aluRes_d;
            storeData_MEM <= fwdB;
            writeReg_MEM  <= RegDst_EX ? Rd_EX : Rt_EX;
            MemRead_MEM   <= bubble ? 1'b0 : MemRead_EX;
            MemWrite_MEM  <= bubble ? 1'b0 : MemWrite_EX;
            MemtoReg_MEM  <= bubble ? 1'b0 : MemtoReg_EX;
            RegWrite_MEM  <= bubble ? 1'b0 : RegWrite_EX;
        end
    end

endmodule

// File: tb/tb_ex_stage.sv
// Bench for ex_stage: directed cases with literal results, then random instruction
// streams compared every cycle against a behavioural pipeline model.
module tb_ex_stage;

    logic        clk;
    logic        rst_n;
    logic [1:0]  ALUOp_EX;
    logic        RegDst_EX, ALUSrc_EX;
    logic        MemRead_EX, MemWrite_EX, MemtoReg_EX, RegWrite_EX;
    logic [31:0] regReadData1_EX, regReadData2_EX, signExtend_EX;
    logic [4:0]  Rt_EX, Rd_EX;
    logic [1:0]  ForwardA, ForwardB;
    logic [31:0] writeData_WB;
    logic [31:0] ALUResult_MEM, storeData_MEM;
    logic [4:0]  writeReg_MEM;
    logic        MemRead_MEM, MemWrite_MEM, MemtoReg_MEM, RegWrite_MEM;
    logic        mulBusy;

    int checks = 0;
    int errors = 0;
    logic checkEn = 1'b0;

    ex_stage dut (
        .clk(clk), .rst_n(rst_n),
        .ALUOp_EX(ALUOp_EX), .RegDst_EX(RegDst_EX), .ALUSrc_EX(ALUSrc_EX),
        .MemRead_EX(MemRead_EX), .MemWrite_EX(MemWrite_EX),
        .MemtoReg_EX(MemtoReg_EX), .RegWrite_EX(RegWrite_EX),
        .regReadData1_EX(regReadData1_EX), .regReadData2_EX(regReadData2_EX),
        .signExtend_EX(signExtend_EX), .Rt_EX(Rt_EX), .Rd_EX(Rd_EX),
        .ForwardA(ForwardA), .ForwardB(ForwardB), .writeData_WB(writeData_WB),
        .ALUResult_MEM(ALUResult_MEM), .storeData_MEM(storeData_MEM),
        .writeReg_MEM(writeReg_MEM), .MemRead_MEM(MemRead_MEM),
        .MemWrite_MEM(MemWrite_MEM), .MemtoReg_MEM(MemtoReg_MEM),
        .RegWrite_MEM(RegWrite_MEM), .mulBusy(mulBusy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    // Behavioural model: mPhase counts edges since a mul was accepted (0 = none in flight)
    logic [31:0] mAlu, mStore, mProd;
    logic [4:0]  mReg;
    logic        mMR, mMW, mM2R, mRW, mValid;
    int          mPhase;

    function automatic logic [31:0] fwdRef(input logic [1:0] sel, input logic [31:0] rf,
                                           input logic [31:0] mem, input logic [31:0] wb);
        if (sel == 2'b10) return mem;
        if (sel == 2'b01) return wb;
        return rf;
    endfunction

    function automatic logic [32:0] refAlu(input logic [1:0] op, input logic [5:0] fn,
                                           input logic [31:0] a, input logic [31:0] b);
        int sa, sb;
        sa = int'(a);
        sb = int'(b);
        case (op)
            2'b00: return {1'b1, a + b};
            2'b01: return {1'b1, a - b};
            2'b11: return {1'b1, (sa < sb) ? 32'd1 : 32'd0};
            default: begin
                case (fn)
                    6'h20: return {1'b1, a + b};
                    6'h22: return {1'b1, a - b};
                    6'h24: return {1'b1, a & b};
                    6'h25: return {1'b1, a | b};
                    6'h2A: return {1'b1, (sa < sb) ? 32'd1 : 32'd0};
                    6'h18: return {1'b0, 32'd0};
                    default: return {1'b1, 32'd0};
                endcase
            end
        endcase
    endfunction

    logic [31:0] refA, refBf, refB;
    logic [32:0] refOut;
    logic        refIsMul, expBusy;

    assign refA     = fwdRef(ForwardA, regReadData1_EX, mAlu, writeData_WB);
    assign refBf    = fwdRef(ForwardB, regReadData2_EX, mAlu, writeData_WB);
    assign refB     = ALUSrc_EX ? signExtend_EX : refBf;
    assign refOut   = refAlu(ALUOp_EX, signExtend_EX[5:0], refA, refB);
    assign refIsMul = (ALUOp_EX == 2'b10) && (signExtend_EX[5:0] == 6'h18) && RegWrite_EX;
    assign expBusy  = rst_n && ((mPhase == 0 && refIsMul) || (mPhase >= 1 && mPhase < 32));

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mAlu <= 0; mStore <= 0; mReg <= 0; mProd <= 0;
            mMR <= 0; mMW <= 0; mM2R <= 0; mRW <= 0; mValid <= 1; mPhase <= 0;
        end else if ((mPhase == 0 && refIsMul) || (mPhase >= 1 && mPhase < 32)) begin
            if (mPhase == 0) mProd <= refA * refB;
            mPhase <= mPhase + 1;
            mMR <= 0; mMW <= 0; mM2R <= 0; mRW <= 0; mValid <= 0;
        end else begin
            mAlu   <= (mPhase == 32) ? mProd : refOut[31:0];
            mValid <= (mPhase == 32) ? 1'b1 : refOut[32];
            mStore <= refBf;
            mReg   <= RegDst_EX ? Rd_EX : Rt_EX;
            mMR <= MemRead_EX; mMW <= MemWrite_EX; mM2R <= MemtoReg_EX; mRW <= RegWrite_EX;
            mPhase <= 0;
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model
    always @(negedge clk) begin
        if (checkEn) begin
            checkOutput("mulBusy", {31'd0, mulBusy}, {31'd0, expBusy});
            checkOutput("ctrl", {28'd0, MemRead_MEM, MemWrite_MEM, MemtoReg_MEM, RegWrite_MEM},
                        {28'd0, mMR, mMW, mM2R, mRW});
            if (mValid) begin
                checkOutput("ALUResult", ALUResult_MEM, mAlu);
                checkOutput("storeData", storeData_MEM, mStore);
                checkOutput("writeReg", {27'd0, writeReg_MEM}, {27'd0, mReg});
            end
        end
    end

    task automatic applyStimulus();
        @(posedge clk);
        #2;
    endtask

    task automatic clearIns();
        ALUOp_EX = 0; RegDst_EX = 0; ALUSrc_EX = 0;
        MemRead_EX = 0; MemWrite_EX = 0; MemtoReg_EX = 0; RegWrite_EX = 0;
        regReadData1_EX = 0; regReadData2_EX = 0; signExtend_EX = 0;
        Rt_EX = 0; Rd_EX = 0; ForwardA = 0; ForwardB = 0; writeData_WB = 0;
    endtask

    task automatic setMul(input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
        clearIns();
        ALUOp_EX = 2'b10; signExtend_EX = 32'h18; RegWrite_EX = 1; RegDst_EX = 1;
        Rd_EX = rd; regReadData1_EX = a; regReadData2_EX = b;
    endtask

    function automatic logic [31:0] rndVal();
        case ($urandom_range(0, 7))
            0: return 32'h0;
            1: return 32'h1;
            2: return 32'hFFFFFFFF;
            3: return 32'h80000000;
            4: return 32'h7FFFFFFF;
            default: return $urandom;
        endcase
    endfunction

    function automatic logic [5:0] rndFunct();
        case ($urandom_range(0, 6))
            0: return 6'h20;
            1: return 6'h22;
            2: return 6'h24;
            3: return 6'h25;
            4: return 6'h2A;
            5: return 6'h18;
            default: return 6'($urandom);
        endcase
    endfunction

    function automatic logic [1:0] rndFwd(input logic memValid);
        logic [1:0] f;
        f = 2'($urandom_range(0, 3));
        if (!memValid && f == 2'b10) f = 2'b00;
        return f;
    endfunction

    initial begin
        int cyc;
        logic [5:0] fn;
        clearIns();
        rst_n = 0;
        repeat (2) @(posedge clk);
        #2 rst_n = 1;
        checkEn = 1;
        checkOutput("resetALU", ALUResult_MEM, 32'd0);
        checkOutput("resetBusy", {31'd0, mulBusy}, 32'd0);

        // add R-type 5 + 7 into r3
        ALUOp_EX = 2'b10; signExtend_EX = 32'h20; regReadData1_EX = 5; regReadData2_EX = 7;
        Rd_EX = 3; Rt_EX = 7; RegDst_EX = 1; RegWrite_EX = 1;
        applyStimulus();
        checkOutput("addResult", ALUResult_MEM, 32'd12);
        checkOutput("addWriteReg", {27'd0, writeReg_MEM}, 32'd3);
        checkOutput("addRegWrite", {31'd0, RegWrite_MEM}, 32'd1);

        // forward ALUResult_MEM=100 into an addi of -1
        clearIns();
        ALUSrc_EX = 1; regReadData1_EX = 100; RegWrite_EX = 1;
        applyStimulus();
        checkOutput("fwdSetup", ALUResult_MEM, 32'd100);
        ForwardA = 2'b10; regReadData1_EX = 0; signExtend_EX = 32'hFFFFFFFF;
        applyStimulus();
        checkOutput("fwdMemAdd", ALUResult_MEM, 32'd99);

        // slt signed both ways, then sw with WB-forwarded data
        clearIns();
        ALUOp_EX = 2'b11; regReadData1_EX = 32'hFFFFFFFF; regReadData2_EX = 1; RegWrite_EX = 1;
        applyStimulus();
        checkOutput("sltNeg", ALUResult_MEM, 32'd1);
        regReadData1_EX = 1; regReadData2_EX = 32'hFFFFFFFF;
        applyStimulus();
        checkOutput("sltPos", ALUResult_MEM, 32'd0);
        clearIns();
        MemWrite_EX = 1; ALUSrc_EX = 1; signExtend_EX = 4; regReadData1_EX = 32'h100;
        regReadData2_EX = 32'h55; ForwardB = 2'b01; writeData_WB = 32'hAB;
        applyStimulus();
        checkOutput("swStore", storeData_MEM, 32'hAB);
        checkOutput("swAddr", ALUResult_MEM, 32'h104);
        checkOutput("swMemWrite", {31'd0, MemWrite_MEM}, 32'd1);

        // zero-control mul encoding must not start a multiply
        clearIns();
        ALUOp_EX = 2'b10; signExtend_EX = 32'h18;
        #1 checkOutput("bubbleNoMul", {31'd0, mulBusy}, 32'd0);
        applyStimulus();

        // async reset between edges, with a mul presented on the inputs
        clearIns();
        ALUSrc_EX = 1; signExtend_EX = 32'h1234; RegWrite_EX = 1;
        applyStimulus();
        setMul(3, 4, 1);
        #1 rst_n = 0;
        #1;
        checkOutput("asyncRstALU", ALUResult_MEM, 32'd0);
        checkOutput("asyncRstRW", {31'd0, RegWrite_MEM}, 32'd0);
        checkOutput("asyncRstBusy", {31'd0, mulBusy}, 32'd0);
        applyStimulus();
        clearIns();
        rst_n = 1;
        applyStimulus();

        // 0x00010003 * 0x00020005, forward inputs disturbed while busy
        begin
            int busyCycles;
            setMul(32'h00010003, 32'h00020005, 9);
            #1;
            busyCycles = 0;
            while (mulBusy && busyCycles < 40) begin
                busyCycles++;
                applyStimulus();
                ForwardA = 2'b01; writeData_WB = $urandom;
                #1;
                if (mulBusy) checkOutput("mulBubble", {31'd0, RegWrite_MEM}, 32'd0);
            end
            checkOutput("mulBusyCycles", busyCycles, 32'd32);
            applyStimulus();
            checkOutput("mulProduct", ALUResult_MEM, 32'h000B000F);
            checkOutput("mulWriteReg", {27'd0, writeReg_MEM}, 32'd9);
            checkOutput("mulRegWrite", {31'd0, RegWrite_MEM}, 32'd1);
            clearIns();
        end

        // reset at cnt=10, then the re-issued 3*4 completes 33 edges later
        begin
            int edges;
            setMul(32'h7, 32'h9, 4);
            repeat (11) applyStimulus();
            setMul(3, 4, 5);
            #1 rst_n = 0;
            #1;
            checkOutput("midRstBusy", {31'd0, mulBusy}, 32'd0);
            checkOutput("midRstALU", ALUResult_MEM, 32'd0);
            applyStimulus();
            rst_n = 1;
            edges = 0;
            while (edges < 40) begin
                applyStimulus();
                edges++;
                if (RegWrite_MEM) break;
            end
            checkOutput("reMulEdges", edges, 32'd33);
            checkOutput("reMulProduct", ALUResult_MEM, 32'd12);
            clearIns();
        end

        // random instruction stream; a mul holds its inputs until completion
        for (cyc = 0; cyc < 3000; cyc++) begin
            if (mPhase != 0) begin
                writeData_WB = rndVal();
                ForwardA = rndFwd(mValid);
                ForwardB = rndFwd(mValid);
            end else begin
                ALUOp_EX = 2'($urandom_range(0, 3));
                fn = rndFunct();
                signExtend_EX = {$urandom, 6'h0} | {26'd0, fn};
                if ($urandom_range(0, 3) == 0) signExtend_EX = rndVal();
                regReadData1_EX = rndVal();
                regReadData2_EX = rndVal();
                writeData_WB = rndVal();
                ALUSrc_EX = 1'($urandom);
                RegDst_EX = 1'($urandom);
                MemRead_EX = 1'($urandom);
                MemWrite_EX = 1'($urandom);
                MemtoReg_EX = 1'($urandom);
                RegWrite_EX = 1'($urandom);
                Rt_EX = 5'($urandom);
                Rd_EX = 5'($urandom);
                ForwardA = rndFwd(mValid);
                ForwardB = rndFwd(mValid);
                if ($urandom_range(0, 9) < 2) begin
                    ALUOp_EX = 2'b10;
                    signExtend_EX[5:0] = 6'h18;
                    RegWrite_EX = 1;
                end
                if (ALUOp_EX == 2'b10 && signExtend_EX[5:0] == 6'h18) RegWrite_EX = 1;
            end
            applyStimulus();
        end

        clearIns();
        applyStimulus();
        checkEn = 0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
